// File: rtl/fourmux_pkg.sv
// Shared types for the 4-to-1 round-robin stream merger.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fourmux_pkg;

    localparam int NUM_CH = 4;

    // Channel index; doubles as the out_sel source tag.
    typedef logic [1:0] ch_idx_t;

    // Occupancy of the single output register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/fourmux_rr_arb4.sv
// Round-robin priority pick over four requests, starting the scan at ptr.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own slot-free term.
//
// Ports:
//   req      4-bit request vector, bit k = channel k
//   ptr      channel with highest priority this cycle
//   gnt      one-hot grant (all zero when nothing requests)
//   gnt_idx  index of the granted channel (equals ptr when any=0)
//   any      at least one request is present
module rr_arb4
    import fourmux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           ptr,
    output logic [NUM_CH-1:0] gnt,
    output ch_idx_t           gnt_idx,
    output logic              any
);

    always_comb begin
        ch_idx_t idx;
        gnt     = '0;
        gnt_idx = ptr;
        any     = 1'b0;
        idx     = ptr;
        // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps mod 4.
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ch_idx_t'(ptr + ch_idx_t'(i));
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fourmux_rr.sv
// Merges four valid/ready producer channels onto one registered output, round-robin.
// Latency: 1 cycle from accept to the beat appearing on out_*; 1 beat/clock sustained.
// Backpressure: out_ready low with a full slot holds out_* and drops every in_ready.
//
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   in_valid   per-channel valid (bit k = channel k)
//   in_data    packed channel data, channel k at [k*DATA_W +: DATA_W]
//   in_ready   per-channel ready, one-hot or zero
//   out_valid  output beat valid
//   out_data   output beat data
//   out_sel    source channel of the current output beat
//   out_ready  consumer ready
module fourmux_rr
    import fourmux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               out_sel,
    input  logic                     out_ready
);

    slot_state_t       state;
    ch_idx_t           ptr;
    logic [NUM_CH-1:0] gnt;
    ch_idx_t           gnt_idx;
    logic              any;
    logic              free;
    logic              accept;
    logic [DATA_W-1:0] win_data;

    rr_arb4 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign out_valid = (state == FULL);

    // The slot can take a new beat if it is empty or draining this cycle.
    assign free = !out_valid || out_ready;

    // The winner always has in_valid set, so a raised ready is an accept.
    assign accept   = any && free && !rst;
    assign in_ready = accept ? gnt : '0;

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_idx == ch_idx_t'(k)) begin
                win_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state    <= FULL;
                        out_data <= win_data;
                        out_sel  <= gnt_idx;
                        ptr      <= ch_idx_t'(gnt_idx + 2'd1);
                    end
                end
                FULL: begin
                    // Drain and refill in the same cycle keeps the slot FULL.
                    if (accept) begin
                        out_data <= win_data;
                        out_sel  <= gnt_idx;
                        ptr      <= ch_idx_t'(gnt_idx + 2'd1);
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fourmux_rr.sv
// Self-checking bench for fourmux_rr: directed scenarios then randomized traffic,
// all compared against a behavioural model of the merger.
module tb_fourmux_rr;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_ready;

    fourmux_rr #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic          m_vld;
    logic [DW-1:0] m_data;
    int            m_sel;
    int            m_ptr;
    int            m_acc;

    // Values observed at the last step's sample point
    logic [3:0]    obs_rdy;
    logic          obs_vld;
    logic [DW-1:0] obs_data;
    logic [1:0]    obs_sel;

    // Random producer state
    logic [3:0]    pend_v;
    logic [DW-1:0] pend_d [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare DUT against the model, advance the model.
    task automatic step(input logic [3:0] v, input logic [4*DW-1:0] d,
                        input logic ordy, input logic r);
        int win;
        int c;
        logic [3:0] exp_rdy;
        logic free;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        #1;
        win  = -1;
        free = !m_vld || ordy;
        for (int i = 0; i < 4; i++) begin
            c = (m_ptr + i) % 4;
            if (win < 0 && v[c]) win = c;
        end
        exp_rdy = 4'b0000;
        if (!r && free && win >= 0) exp_rdy[win] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_sel", 32'(out_sel), 32'(m_sel));
        obs_rdy  = in_ready;
        obs_vld  = out_valid;
        obs_data = out_data;
        obs_sel  = out_sel;
        m_acc = -1;
        if (r) begin
            m_vld  = 1'b0;
            m_data = '0;
            m_sel  = 0;
            m_ptr  = 0;
        end else if (exp_rdy != 4'b0000) begin
            m_vld  = 1'b1;
            m_data = d[win*DW +: DW];
            m_sel  = win;
            m_ptr  = (win + 1) % 4;
            m_acc  = win;
        end else if (ordy) begin
            m_vld = 1'b0;
        end
    endtask

    initial begin
        logic [4*DW-1:0] d;
        logic [4*DW-1:0] rot;
        m_vld = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; m_acc = -1;
        rst = 1'b1; in_valid = 4'b1111; in_data = '0; out_ready = 1'b1;
        pend_v = 4'b0000;
        for (int k = 0; k < 4; k++) pend_d[k] = '0;
        @(posedge clk);

        // Reset held 2 cycles with every channel valid
        step(4'b1111, 32'hDEADBEEF, 1'b1, 1'b1);
        step(4'b1111, 32'hDEADBEEF, 1'b1, 1'b1);
        check("rst_in_ready", 32'(obs_rdy), 32'h0);
        step(4'b1111, 32'h44332211, 1'b1, 1'b0);
        check("first_gnt", 32'(obs_rdy), 32'b0001);
        step(4'b0000, '0, 1'b1, 1'b0);
        check("first_beat", 32'(obs_data), 32'h11);
        step(4'b0000, '0, 1'b1, 1'b0);

        // Single channel 2 (ptr is 1 here)
        step(4'b0100, 32'h00A50000, 1'b1, 1'b0);
        check("single_rdy", 32'(obs_rdy), 32'b0100);
        step(4'b0000, '0, 1'b1, 1'b0);
        check("single_data", 32'(obs_data), 32'hA5);
        check("single_sel", 32'(obs_sel), 32'd2);

        // Wrap and skip: ptr=3, channels 0 and 1 valid
        step(4'b0011, 32'h00000201, 1'b1, 1'b0);
        check("wrap_gnt0", 32'(obs_rdy), 32'b0001);
        step(4'b0010, 32'h00000201, 1'b1, 1'b0);
        check("wrap_gnt1", 32'(obs_rdy), 32'b0010);
        step(4'b1000, 32'h77000000, 1'b1, 1'b0);
        check("wrap_ptr2", 32'(obs_rdy), 32'b1000);
        step(4'b0000, '0, 1'b1, 1'b0);

        // Rotation from ptr=0 with all four valid
        rot = 32'h13121110;
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, rot, 1'b1, 1'b0);
            if (i > 0) begin
                check("rot_sel", 32'(obs_sel), 32'((i - 1) % 4));
                check("rot_vld", 32'(obs_vld), 32'd1);
            end
        end
        step(4'b0000, '0, 1'b1, 1'b0);
        check("rot_last_sel", 32'(obs_sel), 32'd0);

        // Backpressure: beat from channel 1 held, channels 0 and 3 waiting
        step(4'b0010, 32'h00003C00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1001, 32'h99000088, 1'b0, 1'b0);
            check("bp_data", 32'(obs_data), 32'h3C);
            check("bp_sel", 32'(obs_sel), 32'd1);
            check("bp_rdy", 32'(obs_rdy), 32'h0);
        end
        step(4'b1001, 32'h99000088, 1'b1, 1'b0);
        check("bp_release_gnt", 32'(obs_rdy), 32'b1000);
        step(4'b0001, 32'h00000088, 1'b0, 1'b0);
        check("bp_after_sel", 32'(obs_sel), 32'd3);
        check("bp_after_data", 32'(obs_data), 32'h99);

        // Reset while FULL and stalled
        step(4'b1111, 32'h55555555, 1'b0, 1'b1);
        check("midrst_rdy", 32'(obs_rdy), 32'h0);
        step(4'b1111, 32'h55555555, 1'b0, 1'b0);
        check("midrst_vld", 32'(obs_vld), 32'd0);
        check("midrst_ptr0", 32'(obs_rdy), 32'b0001);
        step(4'b0000, '0, 1'b1, 1'b0);
        step(4'b0000, '0, 1'b1, 1'b0);

        // Randomized producers that hold valid/data until granted
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (!pend_v[k] && $urandom_range(0, 1) == 1) begin
                    pend_v[k] = 1'b1;
                    pend_d[k] = DW'($urandom);
                end
            end
            d = {pend_d[3], pend_d[2], pend_d[1], pend_d[0]};
            step(pend_v, d, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
            if (m_acc >= 0) pend_v[m_acc] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
